ysyx_210544_cmt_buf: RTL and testbench

//   Parametrised difftest commit buffer: queues commit records from writeback in a DEPTH-entry FIFO.

---
 rtl/ysyx_210544_cmt_buf.sv | 163 ++++++++++++++++
 tb/tb_ysyx_210544_cmt_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_cmt_buf.sv
// Difftest commit buffer: queues writeback commit records and retires up to COMMIT_W per cycle
// onto registered lanes, isolating interrupt records, detecting the trap instruction and counting.
module ysyx_210544_cmt_buf #(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 8,
    parameter int AW       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [63:0]              i_pc,
    input  logic [31:0]              i_inst,
    input  logic [4:0]               i_rd,
    input  logic                     i_rd_wen,
    input  logic [63:0]              i_rd_wdata,
    input  logic                     i_skip,
    input  logic [31:0]              i_intr_no,
    input  logic [2:0]               i_a0,
    input  logic                     i_drain_en,
    output logic [COMMIT_W-1:0]      o_cmt_valid,
    output logic [COMMIT_W*64-1:0]   o_cmt_pc,
    output logic [COMMIT_W*32-1:0]   o_cmt_inst,
    output logic [COMMIT_W-1:0]      o_cmt_wen,
    output logic [COMMIT_W*8-1:0]    o_cmt_wdest,
    output logic [COMMIT_W*64-1:0]   o_cmt_wdata,
    output logic [COMMIT_W-1:0]      o_cmt_skip,
    output logic [31:0]              o_intr_no,
    output logic [63:0]              o_exc_pc,
    output logic                     o_trap,
    output logic [2:0]               o_trap_code,
    output logic [63:0]              o_trap_pc,
    output logic [63:0]              o_cycle_cnt,
    output logic [63:0]              o_instr_cnt,
    output logic [AW:0]              o_count
);

    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        logic        skip;
        logic [31:0] intr_no;
        logic [2:0]  a0;
    } rec_t;

    rec_t                mem [DEPTH];
    rec_t                in_rec;
    rec_t                lane_rec [COMMIT_W];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic                full;
    logic                enq;
    logic                retire_ok;
    logic                head_intr;
    logic                blocked;
    logic [COMMIT_W-1:0] take;
    logic [CW-1:0]       n_take;
    logic                trap_hit;
    logic [63:0]         trap_pc;
    logic [2:0]          trap_code;

    assign in_rec = '{pc: i_pc, inst: i_inst, rd: i_rd, wen: i_rd_wen, wdata: i_rd_wdata,
                      skip: i_skip, intr_no: i_intr_no, a0: i_a0};

    // Full is judged on the registered count, so a slot freed by this cycle's retire is not reusable yet
    assign full      = (o_count == CW'(DEPTH));
    assign o_ready   = ~full & ~o_trap;
    assign enq       = i_valid & o_ready;
    assign retire_ok = i_drain_en & ~o_trap & (o_count != '0);
    assign head_intr = retire_ok & (lane_rec[0].intr_no != 32'd0);

    for (genvar g = 0; g < COMMIT_W; g++) begin : g_lane
        assign lane_rec[g] = mem[rptr + AW'(g)];
    end

    // Take records in order; an interrupt record ends the group, a trap record is the last one taken
    always_comb begin
        take      = '0;
        n_take    = '0;
        trap_hit  = 1'b0;
        trap_pc   = '0;
        trap_code = '0;
        blocked   = ~retire_ok | head_intr;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (!blocked && (CW'(k) < o_count) && (lane_rec[k].intr_no == 32'd0)) begin
                take[k] = 1'b1;
                n_take  = n_take + CW'(1);
                if (lane_rec[k].inst[6:0] == 7'h6b) begin
                    trap_hit  = 1'b1;
                    trap_pc   = lane_rec[k].pc;
                    trap_code = lane_rec[k].a0;
                    blocked   = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
        if (head_intr) begin
            n_take = CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            mem[wptr] <= in_rec;
        end
    end

    // Retire stage: lane outputs and interrupt report are valid for exactly one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            o_count     <= '0;
            o_cmt_valid <= '0;
            o_cmt_pc    <= '0;
            o_cmt_inst  <= '0;
            o_cmt_wen   <= '0;
            o_cmt_wdest <= '0;
            o_cmt_wdata <= '0;
            o_cmt_skip  <= '0;
            o_intr_no   <= '0;
            o_exc_pc    <= '0;
            o_trap      <= 1'b0;
            o_trap_code <= '0;
            o_trap_pc   <= '0;
            o_cycle_cnt <= '0;
            o_instr_cnt <= '0;
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                o_cmt_valid[k]         <= take[k];
                o_cmt_pc[k*64 +: 64]   <= take[k] ? lane_rec[k].pc : 64'd0;
                o_cmt_inst[k*32 +: 32] <= take[k] ? lane_rec[k].inst : 32'd0;
                o_cmt_wen[k]           <= take[k] & lane_rec[k].wen;
                o_cmt_wdest[k*8 +: 8]  <= take[k] ? {3'd0, lane_rec[k].rd} : 8'd0;
                o_cmt_wdata[k*64 +: 64] <= take[k] ? lane_rec[k].wdata : 64'd0;
                o_cmt_skip[k]          <= take[k] & lane_rec[k].skip;
            end
            o_intr_no <= head_intr ? lane_rec[0].intr_no : 32'd0;
            o_exc_pc  <= head_intr ? lane_rec[0].pc : 64'd0;
            if (trap_hit) begin
                o_trap      <= 1'b1;
                o_trap_code <= trap_code;
                o_trap_pc   <= trap_pc;
            end
            if (!o_trap) begin
                o_cycle_cnt <= o_cycle_cnt + 64'd1;
            end
            o_instr_cnt <= o_instr_cnt + (head_intr ? 64'd0 : 64'(n_take));
            if (enq) begin
                wptr <= wptr + AW'(1);
            end
            rptr    <= rptr + n_take[AW-1:0];
            o_count <= o_count + CW'(enq) - n_take;
        end
    end

endmodule

// File: tb/tb_ysyx_210544_cmt_buf.sv
// Bench for the difftest commit buffer: directed scenarios then random traffic, all checked
// against a queue-based model of the buffer's retire rules.
module tb_ysyx_210544_cmt_buf;

    localparam int W  = 2;
    localparam int D  = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        logic        skip;
        logic [31:0] intr_no;
        logic [2:0]  a0;
    } rec_t;

    logic clk = 1'b0;
    logic rst, i_valid, i_drain_en, o_ready;
    rec_t cur;
    logic [W-1:0]    o_cmt_valid, o_cmt_wen, o_cmt_skip;
    logic [W*64-1:0] o_cmt_pc, o_cmt_wdata;
    logic [W*32-1:0] o_cmt_inst;
    logic [W*8-1:0]  o_cmt_wdest;
    logic [31:0]     o_intr_no;
    logic [63:0]     o_exc_pc, o_trap_pc, o_cycle_cnt, o_instr_cnt;
    logic            o_trap;
    logic [2:0]      o_trap_code;
    logic [AW:0]     o_count;

    always #5 clk = ~clk;

    ysyx_210544_cmt_buf #(.COMMIT_W(W), .DEPTH(D), .AW(AW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(cur.pc), .i_inst(cur.inst), .i_rd(cur.rd), .i_rd_wen(cur.wen),
        .i_rd_wdata(cur.wdata), .i_skip(cur.skip), .i_intr_no(cur.intr_no), .i_a0(cur.a0),
        .i_drain_en(i_drain_en),
        .o_cmt_valid(o_cmt_valid), .o_cmt_pc(o_cmt_pc), .o_cmt_inst(o_cmt_inst),
        .o_cmt_wen(o_cmt_wen), .o_cmt_wdest(o_cmt_wdest), .o_cmt_wdata(o_cmt_wdata),
        .o_cmt_skip(o_cmt_skip), .o_intr_no(o_intr_no), .o_exc_pc(o_exc_pc),
        .o_trap(o_trap), .o_trap_code(o_trap_code), .o_trap_pc(o_trap_pc),
        .o_cycle_cnt(o_cycle_cnt), .o_instr_cnt(o_instr_cnt), .o_count(o_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    rec_t        q[$];
    bit          m_trap;
    logic [2:0]  m_code;
    logic [63:0] m_tpc, m_cyc, m_icnt;
    rec_t        e_lane [W];
    logic [W-1:0] e_valid;
    logic [31:0] e_intr;
    logic [63:0] e_exc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [63:0] pc, input logic [31:0] inst,
                                input logic [31:0] intr, input logic [2:0] a0);
        rec_t r;
        r.pc      = pc;
        r.inst    = inst;
        r.rd      = 5'($urandom);
        r.wen     = 1'($urandom);
        r.wdata   = {$urandom, $urandom};
        r.skip    = 1'($urandom);
        r.intr_no = intr;
        r.a0      = a0;
        return r;
    endfunction

    task automatic model_edge();
        bit old_trap;
        bit rdy;
        bit stop;
        int n;
        old_trap = m_trap;
        e_valid  = '0;
        e_intr   = '0;
        e_exc    = '0;
        for (int k = 0; k < W; k++) e_lane[k] = '0;
        if (rst) begin
            q.delete();
            m_trap = 0; m_code = '0; m_tpc = '0; m_cyc = '0; m_icnt = '0;
            return;
        end
        rdy = (q.size() < D) && !m_trap;
        if (i_drain_en && !m_trap && q.size() > 0) begin
            if (q[0].intr_no != 0) begin
                e_intr = q[0].intr_no;
                e_exc  = q[0].pc;
                void'(q.pop_front());
            end else begin
                n = 0;
                stop = 0;
                while (!stop && n < W && q.size() > 0 && q[0].intr_no == 0) begin
                    e_lane[n]  = q.pop_front();
                    e_valid[n] = 1'b1;
                    m_icnt++;
                    if (e_lane[n].inst[6:0] == 7'h6b) begin
                        m_trap = 1; m_code = e_lane[n].a0; m_tpc = e_lane[n].pc; stop = 1;
                    end
                    n++;
                end
            end
        end
        if (!old_trap) m_cyc++;
        if (i_valid && rdy) q.push_back(cur);
    endtask

    task automatic check_all();
        chk("cmt_valid", o_cmt_valid, e_valid);
        for (int k = 0; k < W; k++) begin
            chk($sformatf("pc%0d", k), o_cmt_pc[k*64 +: 64], e_lane[k].pc);
            chk($sformatf("inst%0d", k), o_cmt_inst[k*32 +: 32], e_lane[k].inst);
            chk($sformatf("wen%0d", k), o_cmt_wen[k], e_lane[k].wen);
            chk($sformatf("wdest%0d", k), o_cmt_wdest[k*8 +: 8], {3'd0, e_lane[k].rd});
            chk($sformatf("wdata%0d", k), o_cmt_wdata[k*64 +: 64], e_lane[k].wdata);
            chk($sformatf("skip%0d", k), o_cmt_skip[k], e_lane[k].skip);
        end
        chk("intr_no", o_intr_no, e_intr);
        chk("exc_pc", o_exc_pc, e_exc);
        chk("trap", o_trap, m_trap);
        chk("trap_code", o_trap_code, m_code);
        chk("trap_pc", o_trap_pc, m_tpc);
        chk("cycle_cnt", o_cycle_cnt, m_cyc);
        chk("instr_cnt", o_instr_cnt, m_icnt);
        chk("count", o_count, q.size());
        chk("ready", o_ready, (q.size() < D) && !m_trap);
    endtask

    task automatic step();
        if (!rst) chk("ready_pre", o_ready, (q.size() < D) && !m_trap);
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(input rec_t r);
        cur = r;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_drain_en = 1'b0; cur = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", o_ready, 1);
        chk("rst_count", o_count, 0);
        chk("rst_valid", o_cmt_valid, 0);

        // Fill to full with drain held off
        for (int k = 0; k < 8; k++) push(mk(64'h8000_0000 + 64'(4*k), 32'h0000_0013, 0, 0));
        chk("full_ready", o_ready, 0);
        chk("full_count", o_count, 8);

        i_drain_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_valid", o_cmt_valid, 2'b11);
            chk("drain_pc0", o_cmt_pc[63:0], 64'h8000_0000 + 64'(8*k));
            chk("drain_pc1", o_cmt_pc[127:64], 64'h8000_0004 + 64'(8*k));
        end
        chk("instr8", o_instr_cnt, 8);
        chk("drained_ready", o_ready, 1);

        // Full buffer: offered record is refused in the retire cycle, accepted the next
        i_drain_en = 1'b0;
        for (int k = 0; k < 8; k++) push(mk(64'h8100_0000 + 64'(4*k), 32'h0000_0013, 0, 0));
        cur = mk(64'h9000_0000, 32'h0000_0033, 0, 0);
        i_valid = 1'b1; i_drain_en = 1'b1;
        step();
        chk("full_enq_count", o_count, 6);
        i_drain_en = 1'b0;
        step();
        chk("full_next_count", o_count, 7);
        i_valid = 1'b0; i_drain_en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("empty_count", o_count, 0);

        // Interrupt record is retired alone between instruction groups
        i_drain_en = 1'b0;
        push(mk(64'hA000, 32'h13, 0, 0));
        push(mk(64'hB000, 32'h13, 7, 0));
        push(mk(64'hC000, 32'h13, 0, 0));
        i_drain_en = 1'b1;
        step();
        chk("intA_valid", o_cmt_valid, 2'b01);
        chk("intA_pc", o_cmt_pc[63:0], 64'hA000);
        step();
        chk("int_no", o_intr_no, 7);
        chk("int_exc", o_exc_pc, 64'hB000);
        chk("int_valid", o_cmt_valid, 0);
        step();
        chk("intB_valid", o_cmt_valid, 2'b01);
        chk("intB_pc", o_cmt_pc[63:0], 64'hC000);
        chk("int_clear", o_intr_no, 0);

        // Trap ends the group, then everything freezes
        i_drain_en = 1'b0;
        push(mk(64'hD000, 32'h0000_006b, 0, 3'd3));
        push(mk(64'hE000, 32'h13, 0, 0));
        i_drain_en = 1'b1;
        step();
        chk("trap_valid", o_cmt_valid, 2'b01);
        chk("trap_flag", o_trap, 1);
        chk("trap_code3", o_trap_code, 3);
        chk("trap_pcD", o_trap_pc, 64'hD000);
        chk("trap_ready", o_ready, 0);
        cur = mk(64'hF000, 32'h13, 0, 0);
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) step();
        i_valid = 1'b0;
        chk("trap_hold_count", o_count, 1);
        chk("trap_hold_valid", o_cmt_valid, 0);

        // Reset with records queued
        rst = 1'b1; step(); rst = 1'b0;
        i_drain_en = 1'b0;
        for (int k = 0; k < 5; k++) push(mk(64'h7000 + 64'(4*k), 32'h13, 0, 0));
        chk("pre_rst_count", o_count, 5);
        rst = 1'b1; step(); rst = 1'b0;
        chk("post_rst_count", o_count, 0);
        chk("post_rst_trap", o_trap, 0);
        chk("post_rst_icnt", o_instr_cnt, 0);
        chk("post_rst_cyc", o_cycle_cnt, 0);

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            logic [31:0] inst;
            logic [31:0] intr;
            inst = $urandom;
            if (inst[6:0] == 7'h6b) inst[0] = 1'b0;
            if ($urandom_range(0, 31) == 0) inst[6:0] = 7'h6b;
            intr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 15)) : 32'd0;
            cur = mk({$urandom, $urandom}, inst, intr, 3'($urandom));
            i_valid = ($urandom_range(0, 3) != 0);
            i_drain_en = ($urandom_range(0, 1) != 0);
            rst = m_trap && ($urandom_range(0, 5) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
